// File: rtl/inc16_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// inc16_rr_arbiter_if
//   Bundles the requester-side and consumer-side handshakes of the shared
//   incrementer arbiter.
//   master : client side (drives req_valid/req_data/rsp_ready)
//   slave  : arbiter side (drives req_ready and the rsp_* result fields)
// Signals
//   req_valid [N_REQ]        requester i has an operand pending
//   req_data  [N_REQ*WIDTH]  operand of requester i at [i*WIDTH +: WIDTH]
//   req_ready [N_REQ]        one-hot grant
//   rsp_valid                result register holds a valid result
//   rsp_data  [WIDTH]        operand + 1
//   rsp_id    [ID_W]         owner of rsp_data
//   rsp_wrap                 operand was all ones
//   rsp_ready                consumer takes the result this cycle
// ----------------------------------------------------------------------------
interface inc16_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int ID_W  = 2
) ();
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   rsp_valid;
   logic [WIDTH-1:0]       rsp_data;
   logic [ID_W-1:0]        rsp_id;
   logic                   rsp_wrap;
   logic                   rsp_ready;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_wrap
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_wrap
   );
endinterface

// File: rtl/inc16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// inc16_rr_arbiter
//   Shares one WIDTH-bit incrementer (out = in + 1) between N_REQ requesters
//   using round-robin arbitration. The result is registered together with
//   the owning requester ID and a wrap flag (operand was all ones).
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : inc16_rr_arbiter_if.slave (requester and consumer handshakes)
// Notes
//   The result register is the only buffering: a new grant is possible when
//   the register is empty or is being drained on the same edge, so full
//   throughput is one result per cycle with rsp_ready held high.
//   ID_W must equal clog2(N_REQ).
// ----------------------------------------------------------------------------
module inc16_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 16,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             reset,
   inc16_rr_arbiter_if.slave bus
);

   // Result register occupancy; the state is exactly rsp_valid.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [ID_W-1:0]  id_q,    id_d;
   logic             wrap_q,  wrap_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;

   logic             accept_s;
   logic             grant_found_s;
   logic [ID_W-1:0]  grant_idx_s;
   logic [ID_W:0]    cand_s;
   logic [N_REQ-1:0] grant_oh_s;
   logic [WIDTH-1:0] sel_data_s;

   // Incremented operand, truncated to WIDTH.
   function automatic logic [WIDTH-1:0] inc_fn(input logic [WIDTH-1:0] v);
      return v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // High when the operand is all ones, i.e. the increment wraps to zero.
   function automatic logic all_ones_fn(input logic [WIDTH-1:0] v);
      return &v;
   endfunction

   // Round-robin search starting at the pointer; first valid requester wins.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_s        = '0;
      for (int off = 0; off < N_REQ; off++) begin
         // One extra bit keeps ptr+off from overflowing before the wrap.
         cand_s = {1'b0, ptr_q} + (ID_W+1)'(off);
         if (cand_s >= (ID_W+1)'(N_REQ)) begin
            cand_s = cand_s - (ID_W+1)'(N_REQ);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_found_s && bus.req_valid[cand_s[ID_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s[ID_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Accept when the result slot is free or draining; reset blocks grants.
   assign accept_s = ~reset
                   & ((state_q == ST_EMPTY) | bus.rsp_ready)
                   & grant_found_s;

   // One-hot grant, all zero when nothing is accepted.
   always_comb begin
      grant_oh_s = '0;
      if (accept_s) begin
         grant_oh_s[grant_idx_s] = 1'b1;
      end else begin
         grant_oh_s = '0;
      end
   end

   assign sel_data_s = bus.req_data[grant_idx_s*WIDTH +: WIDTH];

   // Next-state: load on accept, drain on consumer take, otherwise hold.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      wrap_d  = wrap_q;
      ptr_d   = ptr_q;
      if (accept_s) begin
         // Covers simultaneous drain and accept: new result overwrites old.
         state_d = ST_FULL;
         data_d  = inc_fn(sel_data_s);
         wrap_d  = all_ones_fn(sel_data_s);
         id_d    = grant_idx_s;
         if (grant_idx_s == ID_W'(N_REQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx_s + {{(ID_W-1){1'b0}}, 1'b1};
         end
      end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_q;
      end
   end

   // Result register, pointer and occupancy state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         wrap_q  <= 1'b0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         wrap_q  <= wrap_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.req_ready = grant_oh_s;
   assign bus.rsp_valid = (state_q == ST_FULL);
   assign bus.rsp_data  = data_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_wrap  = wrap_q;

endmodule

// File: tb/tb_inc16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_inc16_rr_arbiter
//   Directed scenarios followed by randomized traffic, compared every cycle
//   against a behavioural model: a set of pending operands per requester, a
//   rotating priority pointer and a one-entry result slot.
// ----------------------------------------------------------------------------
module tb_inc16_rr_arbiter;
   localparam int N = 4;
   localparam int W = 16;

   logic clk;
   logic reset;

   inc16_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(2)) bus ();

   inc16_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Requester-side state as the bench sees it.
   bit          pending [N];
   logic [15:0] pend_data [N];
   int          wait_acc [N];

   // Reference model of the result slot and the fairness pointer.
   bit          m_valid;
   logic [15:0] m_data;
   int          m_id;
   bit          m_wrap;
   int          m_ptr;

   logic [3:0]  last_ready;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = pending[i];
         bus.req_data[i*W +: W]    = pend_data[i];
      end
   endtask

   task automatic model_clear();
      m_valid = 1'b0;
      m_data  = 16'h0000;
      m_id    = 0;
      m_wrap  = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) wait_acc[i] = 0;
   endtask

   // One clock cycle: add new requests, check against model, advance model.
   task automatic step(input logic [3:0] mask, input logic [63:0] data, input logic rdy);
      int         g;
      int         idx;
      bit         any;
      bit         acc;
      logic [3:0] exp_rdy;
      logic [15:0] op;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!pending[i] && mask[i]) begin
            pending[i]   = 1'b1;
            pend_data[i] = data[i*16 +: 16];
         end
      end
      drive_bus();
      bus.rsp_ready = rdy;
      #1;
      any = 1'b0;
      g   = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (pending[idx]) begin
            any = 1'b1;
            if (g < 0) g = idx;
         end
      end
      acc     = (!m_valid || rdy) && any;
      exp_rdy = acc ? (4'b0001 << g) : 4'b0000;
      chk("req_ready", {28'h0, bus.req_ready}, {28'h0, exp_rdy});
      chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, m_valid});
      chk("rsp_data",  {16'h0, bus.rsp_data},  {16'h0, m_data});
      chk("rsp_id",    {30'h0, bus.rsp_id},    m_id);
      chk("rsp_wrap",  {31'h0, bus.rsp_wrap},  {31'h0, m_wrap});
      last_ready = bus.req_ready;
      @(posedge clk);
      if (acc) begin
         op = pend_data[g];
         chk("starve_bound", {31'h0, (wait_acc[g] <= N - 1)}, 32'h1);
         for (int j = 0; j < N; j++) if (pending[j] && j != g) wait_acc[j]++;
         wait_acc[g] = 0;
         m_data  = op + 16'd1;
         m_wrap  = (op == 16'hFFFF);
         m_id    = g;
         m_valid = 1'b1;
         m_ptr   = (g + 1) % N;
         pending[g] = 1'b0;
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   // Constant expectations sampled just after the edge that loaded them.
   task automatic expect_rsp(input string tag, input logic [15:0] d, input int id, input bit wr);
      #1;
      chk({tag, "_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
      chk({tag, "_data"},  {16'h0, bus.rsp_data},  {16'h0, d});
      chk({tag, "_id"},    {30'h0, bus.rsp_id},    id);
      chk({tag, "_wrap"},  {31'h0, bus.rsp_wrap},  {31'h0, wr});
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_req_ready", {28'h0, bus.req_ready}, 32'h0);
      chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst_rsp_data",  {16'h0, bus.rsp_data},  32'h0);
      chk("rst_rsp_id",    {30'h0, bus.rsp_id},    32'h0);
      chk("rst_rsp_wrap",  {31'h0, bus.rsp_wrap},  32'h0);
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         pending[i]   = 1'b0;
         pend_data[i] = 16'h0000;
      end
      drive_bus();
      bus.rsp_ready = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      logic [63:0] rdata;
      logic [3:0]  rmask;
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         pending[i]   = 1'b0;
         pend_data[i] = 16'h0000;
      end
      drive_bus();
      bus.rsp_ready = 1'b0;
      model_clear();
      last_ready = 4'b0000;

      do_reset();

      // 1: single request, first grant after reset
      step(4'b0001, 64'h0000_0000_0000_0001, 1'b1);
      chk("t1_grant", {28'h0, last_ready}, 32'h1);
      expect_rsp("t1", 16'h0002, 0, 1'b0);

      // 2: wrap and non-wrap on requester 1
      step(4'b0010, 64'h0000_0000_FFFF_0000, 1'b1);
      expect_rsp("t2a", 16'h0000, 1, 1'b1);
      step(4'b0010, 64'h0000_0000_0003_0000, 1'b1);
      expect_rsp("t2b", 16'h0004, 1, 1'b0);

      // 3: all requesters continuously valid, full throughput
      for (int c = 0; c < 12; c++) begin
         step(4'b1111, {16'(c + 16'h40), 16'(c + 16'h30), 16'(c + 16'h20), 16'(c + 16'h10)}, 1'b1);
      end

      // 4: backpressure with requester 2 waiting
      step(4'b0000, 64'h0, 1'b1);
      step(4'b0000, 64'h0, 1'b1);
      step(4'b0001, 64'h0000_0000_0000_1234, 1'b1);
      for (int c = 0; c < 3; c++) begin
         step(4'b0100, 64'h0000_5555_0000_0000, 1'b0);
         chk("t4_stall", {28'h0, last_ready}, 32'h0);
      end
      step(4'b0000, 64'h0, 1'b1);
      chk("t4_grant2", {28'h0, last_ready}, 32'h4);
      expect_rsp("t4", 16'h5556, 2, 1'b0);

      // 5: reset while full with a request pending
      step(4'b0001, 64'h0000_0000_0000_0777, 1'b0);
      do_reset();
      step(4'b1000, 64'h7FFF_0000_0000_0000, 1'b1);
      expect_rsp("t5", 16'h8000, 3, 1'b0);

      // 6: pointer past req0 skips idle req1
      step(4'b0001, 64'h0000_0000_0000_0010, 1'b1);
      step(4'b0101, 64'h0000_0020_0000_0030, 1'b1);
      chk("t6_grant2", {28'h0, last_ready}, 32'h4);
      step(4'b0000, 64'h0, 1'b1);
      chk("t6_grant0", {28'h0, last_ready}, 32'h1);
      expect_rsp("t6", 16'h0031, 0, 1'b0);

      // Randomized traffic with corner operands and random backpressure
      for (int c = 0; c < 3000; c++) begin
         rmask = 4'($urandom);
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       rdata[i*16 +: 16] = 16'hFFFF;
               1:       rdata[i*16 +: 16] = 16'h0000;
               default: rdata[i*16 +: 16] = 16'($urandom);
            endcase
         end
         step(rmask, rdata, ($urandom_range(0, 3) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
